// File: rtl/expr_tx.sv
// expr_tx: serialises a packed operand/operator descriptor into an infix
// expression of 9-bit ASCII characters (digit, op, digit, ..., digit) over a
// valid/ready link. Every output comes straight from a flop.
// Optional feature: define EXPR_TX_EVAL_EN to evaluate the expression
// ('*' binds tighter than '+') as the characters are accepted and report it
// on result/result_valid. Without it, result and result_valid are tied to 0.
module expr_tx #(
  parameter int MAX_TERMS = 8
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     start,
  input  logic [3:0]               nterms,
  input  logic [4*MAX_TERMS-1:0]   digits,
  input  logic [MAX_TERMS-2:0]     ops,
  output logic [8:0]               out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              result,
  output logic                     result_valid
);

  localparam int IW = $clog2(MAX_TERMS);

  typedef enum logic [1:0] {IDLE, DIGIT, OP, DONE} state_t;

  state_t                 state, state_nxt;
  logic [IW-1:0]          idx, idx_nxt;
  logic [3:0]             n_q, n_src;
  logic [4*MAX_TERMS-1:0] dig_q, dig_src;
  logic [MAX_TERMS-1:0]   ops_q, ops_src;
  logic                   load, accept, last_term;
  logic [8:0]             char_nxt;
  logic                   last_nxt;

  // Nibbles above 9 are clamped so every operand is a single decimal digit.
  function automatic logic [3:0] sat_digit(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

  function automatic logic [8:0] digit_char(input logic [3:0] n);
    return 9'h030 + {5'b0, sat_digit(n)};
  endfunction

  function automatic logic [8:0] op_char(input logic mul);
    return mul ? 9'h02A : 9'h02B;
  endfunction

  // Next-state logic plus the character the output register will hold next.
  always_comb begin
    load      = (state == IDLE) && start && (nterms != 4'd0) &&
                ({1'b0, nterms} <= 5'(MAX_TERMS));
    accept    = out_valid & out_ready;
    last_term = (4'(idx) == n_q - 4'd1);
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (load) begin
          state_nxt = DIGIT;
          idx_nxt   = '0;
        end
      end
      DIGIT: begin
        if (accept) state_nxt = last_term ? DONE : OP;
      end
      OP: begin
        if (accept) begin
          idx_nxt   = idx + IW'(1);
          state_nxt = DIGIT;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // On the load edge the descriptor flops are not yet written, so the first
    // character is taken from the input ports directly.
    n_src    = load ? nterms : n_q;
    dig_src  = load ? digits : dig_q;
    ops_src  = load ? {1'b0, ops} : ops_q;
    char_nxt = 9'h000;
    if (state_nxt == DIGIT)   char_nxt = digit_char(dig_src[{idx_nxt, 2'b00} +: 4]);
    else if (state_nxt == OP) char_nxt = op_char(ops_src[idx_nxt]);
    last_nxt = (state_nxt == DIGIT) && (4'(idx_nxt) == n_src - 4'd1);
  end

  // State and operand index; clr abandons any expression in flight.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Descriptor is captured once per expression so later port changes are ignored.
  always_ff @(posedge clk) begin
    if (load) begin
      n_q   <= nterms;
      dig_q <= digits;
      ops_q <= {1'b0, ops};
    end
  end

  // Registered link outputs, precomputed from the next state.
  always_ff @(posedge clk) begin
    if (clr) begin
      out       <= 9'h000;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      out       <= char_nxt;
      out_valid <= (state_nxt == DIGIT) || (state_nxt == OP);
      out_last  <= last_nxt;
      busy      <= (state_nxt != IDLE);
      done      <= (state_nxt == DONE);
    end
  end

`ifdef EXPR_TX_EVAL_EN
  logic [15:0] s_q, p_q, p_mul;
  logic [3:0]  cur_digit;
  logic        cur_op;

  function automatic logic [15:0] mul16x4(input logic [15:0] a, input logic [3:0] b);
    logic [19:0] prod;
    prod = {4'b0, a} * {16'b0, b};
    return prod[15:0];
  endfunction

  // Running product of the current '*' chain, scaled by the digit on the link.
  always_comb begin
    cur_digit = sat_digit(dig_q[{idx, 2'b00} +: 4]);
    cur_op    = ops_q[idx];
    p_mul     = mul16x4(p_q, cur_digit);
  end

  // Sum-of-products accumulator; result is published with the DONE cycle.
  always_ff @(posedge clk) begin
    if (clr) begin
      s_q          <= 16'd0;
      p_q          <= 16'd1;
      result       <= 16'd0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (load) begin
        s_q    <= 16'd0;
        p_q    <= 16'd1;
        result <= 16'd0;
      end else if ((state == DIGIT) && accept) begin
        p_q <= p_mul;
        if (last_term) begin
          result       <= s_q + p_mul;
          result_valid <= 1'b1;
        end
      end else if ((state == OP) && accept && !cur_op) begin
        s_q <= s_q + p_q;
        p_q <= 16'd1;
      end
    end
  end
`else
  assign result       = 16'd0;
  assign result_valid = 1'b0;
`endif

endmodule

// File: tb/tb_expr_tx.sv
// Self-checking bench for expr_tx: directed protocol cases plus randomized
// descriptors and random back-pressure, compared against a term-list model.
module tb_expr_tx;
  localparam int MT = 8;

  logic        clk = 1'b0;
  logic        clr, start, out_ready;
  logic [3:0]  nterms;
  logic [31:0] digits;
  logic [6:0]  ops;
  logic [8:0]  out;
  logic        out_valid, out_last, busy, done, result_valid;
  logic [15:0] result;

  int total = 0;
  int bad   = 0;

  logic [8:0]  exp_q[$];
  logic [15:0] exp_res;

  expr_tx #(.MAX_TERMS(MT)) dut (
    .clk(clk), .clr(clr), .start(start), .nterms(nterms), .digits(digits),
    .ops(ops), .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done), .result(result),
    .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out"}, 32'(out), 32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_last"}, 32'(out_last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_result"}, 32'(result), 32'd0);
    chk({tag, "_rvalid"}, 32'(result_valid), 32'd0);
  endtask

  // Expected character list and value: split into '+'-separated product terms.
  task automatic model(input int n, input logic [31:0] dg, input logic [6:0] op);
    int terms[$];
    int prod, d, sum;
    logic [3:0] nib;
    exp_q.delete();
    prod = 1;
    for (int i = 0; i < n; i++) begin
      nib = dg[4*i +: 4];
      d = int'(nib);
      if (d > 9) d = 9;
      exp_q.push_back(9'(48 + d));
      prod = prod * d;
      if (i < n - 1) begin
        if (op[i]) exp_q.push_back(9'h02A);
        else begin
          exp_q.push_back(9'h02B);
          terms.push_back(prod);
          prod = 1;
        end
      end
    end
    terms.push_back(prod);
    sum = 0;
    foreach (terms[k]) sum += terms[k];
`ifdef EXPR_TX_EVAL_EN
    exp_res = 16'(sum);
`else
    exp_res = 16'd0;
`endif
  endtask

  // mode 0: ready always high; 1: random ready; 2: 3-cycle stall on char 1.
  task automatic send(input int n, input logic [31:0] dg, input logic [6:0] op,
                      input int mode, input bit busy_start);
    int pos, stall, cyc, len;
    logic r;
    model(n, dg, op);
    len = exp_q.size();
    nterms = 4'(n); digits = dg; ops = op; start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0;
    if (busy_start) begin
      digits = $urandom; ops = 7'($urandom); nterms = 4'($urandom_range(1, MT));
      start = 1'b1;
    end
    pos = 0; stall = 0; cyc = 0;
    while (pos < len && cyc < 300) begin
      chk("valid", 32'(out_valid), 32'd1);
      chk("char", 32'(out), 32'(exp_q[pos]));
      chk("last", 32'(out_last), 32'(pos == len - 1));
      chk("busy", 32'(busy), 32'd1);
      chk("done_early", 32'(done), 32'd0);
      r = 1'b1;
      if (mode == 1) r = 1'($urandom_range(0, 1));
      else if (mode == 2 && pos == 1 && stall < 3) begin
        r = 1'b0;
        stall++;
      end
      out_ready = r;
      step();
      if (r) pos++;
      cyc++;
    end
    if (pos < len) chk("stream_timeout", 32'(pos), 32'(len));
    chk("done", 32'(done), 32'd1);
    chk("done_valid", 32'(out_valid), 32'd0);
    chk("done_busy", 32'(busy), 32'd1);
`ifdef EXPR_TX_EVAL_EN
    chk("result_valid", 32'(result_valid), 32'd1);
`else
    chk("result_valid", 32'(result_valid), 32'd0);
`endif
    chk("result", 32'(result), 32'(exp_res));
    out_ready = 1'($urandom_range(0, 1));
    step();
    start = 1'b0;
    chk("post_done", 32'(done), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_valid", 32'(out_valid), 32'd0);
    chk("result_hold", 32'(result), 32'(exp_res));
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; out_ready = 1'b0;
    nterms = 4'd0; digits = 32'd0; ops = 7'd0;
    step(); step();
    chk_all_zero("reset");
    clr = 1'b0;
    step();
    chk_all_zero("idle");

    // Basic stream 2*1+3
    send(3, 32'h0000_0312, 7'b0000001, 0, 1'b0);
    // Back-pressure on the '*' character
    send(3, 32'h0000_0312, 7'b0000001, 2, 1'b0);
    // Single term
    send(1, 32'h0000_0007, 7'b0000000, 0, 1'b0);

    // Illegal operand counts are ignored
    nterms = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("n0_valid", 32'(out_valid), 32'd0);
      chk("n0_busy", 32'(busy), 32'd0);
      step();
    end
    nterms = 4'd9; start = 1'b1;
    step();
    start = 1'b0;
    chk("n9_valid", 32'(out_valid), 32'd0);
    chk("n9_busy", 32'(busy), 32'd0);

    // clr wins over start in the same cycle
    clr = 1'b1; start = 1'b1; nterms = 4'd3; digits = 32'h0000_0312; ops = 7'b0000001;
    step();
    clr = 1'b0; start = 1'b0;
    chk("clr_start_busy", 32'(busy), 32'd0);
    step();
    chk("clr_start_busy2", 32'(busy), 32'd0);

    // Reset mid-stream, one cycle after '1' is accepted
    nterms = 4'd3; digits = 32'h0000_0312; ops = 7'b0000001; start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    chk("mid_char1", 32'(out), 32'h31);
    step();
    chk("mid_plus", 32'(out), 32'h2B);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk_all_zero("mid_clr");
    for (int i = 0; i < 6; i++) begin
      chk("mid_no_done", 32'(done), 32'd0);
      chk("mid_no_valid", 32'(out_valid), 32'd0);
      step();
    end
    send(3, 32'h0000_0312, 7'b0000001, 0, 1'b0);

    // Start while busy (including DONE cycle) ignored
    send(3, 32'h0000_0312, 7'b0000001, 0, 1'b1);
    // Precedence and clamped nibble: 9*9*9+C -> 738, 'C' sent as '9'
    send(4, 32'h0000_C999, 7'b0000011, 0, 1'b0);
    send(MT, 32'hFEDC_BA98, 7'b1010101, 1, 1'b0);

    // Randomized descriptors with random back-pressure
    for (int t = 0; t < 25; t++) begin
      send($urandom_range(1, MT), $urandom, 7'($urandom), 1, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
